// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and constants for the SDRAM read-port arbiter.
package jtframe_sdram_arb_pkg;

  localparam int unsigned DW      = 32;
  localparam int unsigned SdramAw = 22;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StWaitRdy
  } state_e;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Round-robin priority encoder: first set request at or after rr_i, wrapping.
module jtframe_rr_pick #(
  parameter int unsigned Slots = 4,
  parameter int unsigned IdxW  = $clog2(Slots)
) (
  input  logic [Slots-1:0] req_i,
  input  logic [IdxW-1:0]  rr_i,
  output logic [IdxW-1:0]  gnt_o,
  output logic             any_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    gnt_o = '0;
    for (int unsigned k = 0; k < Slots; k++) begin
      idx = (32'(rr_i) + k) % Slots;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gnt_o = IdxW'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Arbitrates SLOTS cached ROM requesters onto one SDRAM read port,
// one access in flight, misses granted round-robin.
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 22
) (
  input  logic                  clk_rom,
  input  logic                  rst_n,
  input  logic                  loop_rst,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_req,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*DW-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [SdramAw-1:0]    sdram_addr,
  input  logic                  sdram_ack,
  input  logic [DW-1:0]         data_read,
  input  logic                  data_rdy,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(SLOTS);

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            gnt_q, gnt_d;
  logic [IdxW-1:0]            rr_q, rr_d;
  logic                       req_q, req_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [SLOTS-1:0]           valid_q, valid_d;
  logic [SLOTS-1:0][AW-1:0]   tag_q, tag_d;
  logic [SLOTS-1:0][DW-1:0]   data_q, data_d;

  logic [SLOTS-1:0][AW-1:0]   addr_a;
  logic [SLOTS-1:0]           hit;
  logic [SLOTS-1:0]           miss;
  logic [IdxW-1:0]            pick_gnt;
  logic                       pick_any;
  logic                       fill;

  assign addr_a = slot_addr;

  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      hit[i] = slot_req[i] & valid_q[i] & (addr_a[i] == tag_q[i]);
    end
  end

  assign miss = slot_req & ~hit;

  jtframe_rr_pick #(
    .Slots (SLOTS),
    .IdxW  (IdxW)
  ) u_pick (
    .req_i (miss),
    .rr_i  (rr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    fill    = 1'b0;

    if (loop_rst) begin
      // Controller re-init: drop everything, any late data_rdy is ignored.
      state_d = StIdle;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any && !downloading) begin
            gnt_d   = pick_gnt;
            addr_d  = addr_a[pick_gnt];
            req_d   = 1'b1;
            state_d = StWaitAck;
          end
        end
        StWaitAck: begin
          if (sdram_ack) begin
            req_d = 1'b0;
            if (data_rdy) begin
              fill    = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StWaitRdy;
            end
          end
        end
        StWaitRdy: begin
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (fill) begin
        rr_d = (gnt_q == IdxW'(SLOTS - 1)) ? '0 : gnt_q + 1'b1;
        if (!downloading) begin
          tag_d[gnt_q]   = addr_q;
          data_d[gnt_q]  = data_read;
          valid_d[gnt_q] = 1'b1;
        end
      end

      if (downloading) valid_d = '0;
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign slot_ok    = hit;
  assign slot_dout  = data_q;
  assign sdram_req  = req_q;
  assign sdram_addr = SdramAw'(addr_q);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: scoreboard of expected SDRAM grant addresses.
module tb_jtframe_sdram_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;

  logic                  clk_rom     = 1'b0;
  logic                  rst_n       = 1'b0;
  logic                  loop_rst    = 1'b0;
  logic                  downloading = 1'b0;
  logic [SLOTS-1:0]      slot_req    = '0;
  logic [SLOTS*AW-1:0]   slot_addr   = '0;
  logic                  sdram_ack   = 1'b0;
  logic [31:0]           data_read   = '0;
  logic                  data_rdy    = 1'b0;
  logic [SLOTS-1:0]      slot_ok;
  logic [SLOTS*32-1:0]   slot_dout;
  logic                  sdram_req;
  logic [21:0]           sdram_addr;
  logic                  busy;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [21:0] exp_q[$];

  jtframe_sdram_arb #(
    .SLOTS (SLOTS),
    .AW    (AW)
  ) dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .loop_rst    (loop_rst),
    .downloading (downloading),
    .slot_req    (slot_req),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_read   (data_read),
    .data_rdy    (data_rdy),
    .busy        (busy)
  );

  always #5 clk_rom = ~clk_rom;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic set_slot(input int i, input logic req, input logic [21:0] a);
    slot_req[i]            = req;
    slot_addr[i*AW +: AW]  = a;
  endtask

  task automatic do_reset();
    slot_req  = '0;
    rst_n     = 1'b0;
    #3;
    rst_n     = 1'b1;
    tick();
  endtask

  // Wait (bounded) for the next grant and pop the address the scoreboard expects.
  task automatic grab(output bit seen, output logic [21:0] got, output logic [21:0] want);
    for (int c = 0; c < 20 && sdram_req !== 1'b1; c++) tick();
    seen = (sdram_req === 1'b1);
    got  = sdram_addr;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3fffff;
  endtask

  task automatic complete(input logic [31:0] d);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_read = d;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({sdram_req, busy, slot_ok, sdram_addr} !== '0 || slot_dout !== '0) begin
      tests_failed++;
      $display("FAIL reset: req=%b busy=%b ok=%b addr=%h dout=%h, want all 0",
               sdram_req, busy, slot_ok, sdram_addr, slot_dout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_miss();
    bit seen;
    logic [21:0] got, want;
    set_slot(0, 1'b1, 22'h1234);
    exp_q.push_back(22'h001234);
    #1;
    tests_run++;
    if (sdram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_cycle_n: sdram_req=%b want 0", sdram_req);
    end
    tick();
    tests_run++;
    if (sdram_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL miss_latency: sdram_req=%b want 1 one cycle after miss", sdram_req);
    end
    grab(seen, got, want);
    tests_run++;
    if (!seen || got !== want) begin
      tests_failed++;
      $display("FAIL single_addr: seen=%b addr=%h want %h", seen, got, want);
    end
    complete(32'hDEADBEEF);
    tests_run++;
    if (slot_ok[0] !== 1'b1 || slot_dout[31:0] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL single_fill: ok=%b dout=%h want 1 deadbeef", slot_ok[0], slot_dout[31:0]);
    end
  endtask

  task automatic test_hit();
    tick();
    tests_run++;
    if (sdram_req !== 1'b0 || slot_ok[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit_hold: req=%b ok=%b want 0 1", sdram_req, slot_ok[0]);
    end
    set_slot(0, 1'b0, 22'h1234);
    #1;
    tests_run++;
    if (slot_ok[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_noreq: ok=%b want 0", slot_ok[0]);
    end
    tick();
    set_slot(0, 1'b1, 22'h1234);
    #1;
    tests_run++;
    if (slot_ok[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit_same_cycle: ok=%b want 1", slot_ok[0]);
    end
    tick();
    tests_run++;
    if (sdram_req !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_no_traffic: req=%b busy=%b want 0 0", sdram_req, busy);
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    logic [21:0] got, want;
    do_reset();
    for (int i = 0; i < SLOTS; i++) begin
      set_slot(i, 1'b1, 22'h100 + 22'(i));
      exp_q.push_back(22'h100 + 22'(i));
    end
    for (int i = 0; i < SLOTS; i++) begin
      grab(seen, got, want);
      tests_run++;
      if (!seen || got !== want) begin
        tests_failed++;
        $display("FAIL rr_order%0d: seen=%b addr=%h want %h", i, seen, got, want);
      end
      complete(32'hA0 + 32'(i));
    end
    tests_run++;
    if (slot_ok !== 4'hF) begin
      tests_failed++;
      $display("FAIL rr_all_ok: ok=%b want 1111", slot_ok);
    end
    for (int i = 0; i < SLOTS; i++) begin
      tests_run++;
      if (slot_dout[i*32 +: 32] !== 32'hA0 + 32'(i)) begin
        tests_failed++;
        $display("FAIL rr_dout%0d: dout=%h want %h", i, slot_dout[i*32 +: 32], 32'hA0 + 32'(i));
      end
    end
    // rr is back at 0; one slot1 access moves it to 2.
    set_slot(1, 1'b1, 22'h201);
    exp_q.push_back(22'h201);
    grab(seen, got, want);
    tests_run++;
    if (!seen || got !== want) begin
      tests_failed++;
      $display("FAIL rr_slot1: seen=%b addr=%h want %h", seen, got, want);
    end
    complete(32'hB1);
    set_slot(0, 1'b1, 22'h300);
    set_slot(2, 1'b1, 22'h302);
    exp_q.push_back(22'h302);
    exp_q.push_back(22'h300);
    for (int i = 0; i < 2; i++) begin
      grab(seen, got, want);
      tests_run++;
      if (!seen || got !== want) begin
        tests_failed++;
        $display("FAIL rr_wrap%0d: seen=%b addr=%h want %h", i, seen, got, want);
      end
      complete(32'hC0 + 32'(i));
    end
    tests_run++;
    if (slot_ok !== 4'hF) begin
      tests_failed++;
      $display("FAIL rr_wrap_ok: ok=%b want 1111", slot_ok);
    end
  endtask

  task automatic test_addr_change();
    bit seen;
    logic [21:0] got, want;
    slot_req = '0;
    set_slot(1, 1'b1, 22'h10);
    exp_q.push_back(22'h10);
    grab(seen, got, want);
    tests_run++;
    if (!seen || got !== want) begin
      tests_failed++;
      $display("FAIL chg_first: seen=%b addr=%h want %h", seen, got, want);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    set_slot(1, 1'b1, 22'h20);
    data_read = 32'h1111;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    tests_run++;
    if (slot_ok[1] !== 1'b0 || slot_dout[63:32] !== 32'h1111) begin
      tests_failed++;
      $display("FAIL chg_stale: ok=%b dout=%h want 0 00001111", slot_ok[1], slot_dout[63:32]);
    end
    exp_q.push_back(22'h20);
    grab(seen, got, want);
    tests_run++;
    if (!seen || got !== want) begin
      tests_failed++;
      $display("FAIL chg_refetch: seen=%b addr=%h want %h", seen, got, want);
    end
    complete(32'h2222);
    tests_run++;
    if (slot_ok[1] !== 1'b1 || slot_dout[63:32] !== 32'h2222) begin
      tests_failed++;
      $display("FAIL chg_fill: ok=%b dout=%h want 1 00002222", slot_ok[1], slot_dout[63:32]);
    end
  endtask

  task automatic test_loop_rst();
    bit seen;
    logic [21:0] got, want;
    set_slot(3, 1'b1, 22'h33);
    exp_q.push_back(22'h33);
    grab(seen, got, want);
    tests_run++;
    if (!seen || got !== want || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL lrst_grant: seen=%b addr=%h busy=%b want %h busy 1", seen, got, busy, want);
    end
    loop_rst = 1'b1;
    slot_req = '0;
    tick();
    loop_rst = 1'b0;
    tests_run++;
    if (sdram_req !== 1'b0 || busy !== 1'b0 || slot_ok !== '0) begin
      tests_failed++;
      $display("FAIL lrst_abort: req=%b busy=%b ok=%b want 0 0 0", sdram_req, busy, slot_ok);
    end
    data_read = 32'h0BAD;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    tests_run++;
    if (slot_dout[127:96] !== 32'hA3 || slot_dout[63:32] !== 32'h2222 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lrst_late_rdy: dout3=%h dout1=%h busy=%b want a3 2222 0",
               slot_dout[127:96], slot_dout[63:32], busy);
    end
    set_slot(1, 1'b1, 22'h20);
    #1;
    tests_run++;
    if (slot_ok[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL lrst_valid_clr: ok=%b want 0", slot_ok[1]);
    end
  endtask

  task automatic test_downloading();
    bit seen;
    int req_cnt;
    logic [21:0] got, want;
    exp_q.push_back(22'h20);
    grab(seen, got, want);
    tests_run++;
    if (!seen || got !== want) begin
      tests_failed++;
      $display("FAIL dl_prefill: seen=%b addr=%h want %h", seen, got, want);
    end
    complete(32'h2222);
    downloading = 1'b1;
    tick();
    tests_run++;
    if (slot_ok[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL dl_valid_clr: ok=%b want 0", slot_ok[1]);
    end
    set_slot(0, 1'b1, 22'h40);
    req_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sdram_req === 1'b1) req_cnt++;
    end
    tests_run++;
    if (req_cnt !== 0) begin
      tests_failed++;
      $display("FAIL dl_no_grant: req cycles=%0d want 0", req_cnt);
    end
    downloading = 1'b0;
    exp_q.push_back(22'h40);
    exp_q.push_back(22'h20);
    for (int i = 0; i < 2; i++) begin
      grab(seen, got, want);
      tests_run++;
      if (!seen || got !== want) begin
        tests_failed++;
        $display("FAIL dl_refetch%0d: seen=%b addr=%h want %h", i, seen, got, want);
      end
      complete(32'h4040 + 32'(i));
    end
    tests_run++;
    if (slot_ok[1:0] !== 2'b11) begin
      tests_failed++;
      $display("FAIL dl_refilled: ok=%b want 11", slot_ok[1:0]);
    end
    // Fill landing while downloading must leave the slot invalid.
    set_slot(0, 1'b1, 22'h41);
    exp_q.push_back(22'h41);
    grab(seen, got, want);
    sdram_ack   = 1'b1;
    tick();
    sdram_ack   = 1'b0;
    downloading = 1'b1;
    data_read   = 32'h9999;
    data_rdy    = 1'b1;
    tick();
    data_rdy    = 1'b0;
    tests_run++;
    if (!seen || got !== want || slot_ok[0] !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dl_discard: seen=%b addr=%h ok=%b busy=%b want %h 0 0",
               seen, got, slot_ok[0], busy, want);
    end
    slot_req    = '0;
    downloading = 1'b0;
    tick();
  endtask

  task automatic test_ack_rdy_same();
    bit seen;
    logic [21:0] got, want;
    set_slot(2, 1'b1, 22'h55);
    exp_q.push_back(22'h55);
    grab(seen, got, want);
    tests_run++;
    if (!seen || got !== want) begin
      tests_failed++;
      $display("FAIL same_grant: seen=%b addr=%h want %h", seen, got, want);
    end
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'h5555;
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || sdram_req !== 1'b0 || slot_ok[2] !== 1'b1
        || slot_dout[95:64] !== 32'h5555) begin
      tests_failed++;
      $display("FAIL same_cycle_done: busy=%b req=%b ok=%b dout=%h want 0 0 1 5555",
               busy, sdram_req, slot_ok[2], slot_dout[95:64]);
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_hit();
    test_round_robin();
    test_addr_change();
    test_loop_rst();
    test_downloading();
    test_ack_rdy_same();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
